// File: rtl/motion_sequencer_pkg.sv
// motion_sequencer_pkg: direction codes, state encoding and duty ramp helper shared with the motor direction decoder
package motion_sequencer_pkg;

    typedef enum logic [2:0] {
        DIR_STOP  = 3'd0,
        DIR_FWD   = 3'd1,
        DIR_BACK  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEAD,
        ST_RAMP,
        ST_RUN
    } state_e;

    function automatic logic dir_valid(input logic [2:0] d);
        return d <= DIR_RIGHT;
    endfunction

    // One ramp step toward tgt; integer math so large steps clamp at tgt instead of wrapping.
    function automatic logic [7:0] ramp_next(input logic [7:0] cur, input logic [7:0] tgt, input int step);
        int c;
        int t;
        c = int'(cur);
        t = int'(tgt);
        if (c < t) return (t - c <= step) ? tgt : 8'(c + step);
        return (c - t <= step) ? tgt : 8'(c - step);
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: free-running prescaler producing a 1-cycle tick every TICK_DIV cycles
// Ports: clock_in, reset (sync, active high), restart (force count to 0), tick (pulse at count TICK_DIV-1)
module ms_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clock_in,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(TICK_DIV - 1));
        cnt_d = (restart || tick) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clock_in) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/motion_sequencer.sv
// motion_sequencer: command-driven motor sequencer with dead time on reversal, duty ramping and timed runs
// Ports: clock_in/reset (sync, active high); cmd_valid/cmd_ready handshake with cmd_direction, cmd_duty,
// cmd_duration; abort; registered outputs robot_direction, left_duty, right_duty, busy, cmd_error.
module motion_sequencer
    import motion_sequencer_pkg::*;
#(
    parameter int TICK_DIV  = 50000,
    parameter int DEAD_MS   = 20,
    parameter int RAMP_STEP = 8
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_direction,
    input  logic [7:0]  cmd_duty,
    input  logic [15:0] cmd_duration,
    input  logic        abort,
    output logic [2:0]  robot_direction,
    output logic [7:0]  left_duty,
    output logic [7:0]  right_duty,
    output logic        busy,
    output logic        cmd_error
);

    localparam int DW = $clog2(DEAD_MS + 1);

    state_e        state_q, state_d;
    logic [2:0]    dir_q, dir_d, tgt_dir_q, tgt_dir_d;
    logic [7:0]    duty_q, duty_d, tgt_duty_q, tgt_duty_d;
    logic [15:0]   dur_q, dur_d, run_cnt_q, run_cnt_d;
    logic [DW-1:0] dead_cnt_q, dead_cnt_d;
    logic          ready_q, ready_d, busy_q, busy_d, err_q, err_d;
    logic          accept, tick;

    // abort wins over a simultaneous command, so it also blocks the handshake
    assign accept = cmd_valid && ready_q && !abort;

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock_in (clock_in),
        .reset    (reset),
        .restart  (accept),
        .tick     (tick)
    );

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        duty_d     = duty_q;
        tgt_dir_d  = tgt_dir_q;
        tgt_duty_d = tgt_duty_q;
        dur_d      = dur_q;
        run_cnt_d  = run_cnt_q;
        dead_cnt_d = dead_cnt_q;
        err_d      = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            dir_d   = DIR_STOP;
            duty_d  = '0;
            dur_d   = '0;
        end else if (accept) begin
            tgt_dir_d  = cmd_direction;
            tgt_duty_d = cmd_duty;
            dur_d      = cmd_duration;
            run_cnt_d  = '0;
            dead_cnt_d = '0;
            if (!dir_valid(cmd_direction) || cmd_direction == DIR_STOP) begin
                err_d   = !dir_valid(cmd_direction);
                state_d = ST_IDLE;
                dir_d   = DIR_STOP;
                duty_d  = '0;
                dur_d   = '0;
            end else if (dir_q != DIR_STOP && cmd_direction != dir_q) begin
                state_d = ST_DEAD;
                dir_d   = DIR_STOP;
                duty_d  = '0;
            end else begin
                state_d = ST_RAMP;
                dir_d   = cmd_direction;
            end
        end else if (state_q == ST_DEAD) begin
            if (tick) begin
                dead_cnt_d = dead_cnt_q + 1'b1;
                if (dead_cnt_q == DW'(DEAD_MS - 1)) begin
                    state_d    = ST_RAMP;
                    dir_d      = tgt_dir_q;
                    dead_cnt_d = '0;
                end
            end
        end else if (state_q == ST_RAMP) begin
            // entering with duty already at target costs exactly one RAMP cycle
            if (duty_q == tgt_duty_q) begin
                state_d   = ST_RUN;
                run_cnt_d = '0;
            end else if (tick) begin
                duty_d = ramp_next(duty_q, tgt_duty_q, RAMP_STEP);
                if (duty_d == tgt_duty_q) begin
                    state_d   = ST_RUN;
                    run_cnt_d = '0;
                end
            end
        end else if (state_q == ST_RUN) begin
            if (dur_q != '0 && tick) begin
                run_cnt_d = run_cnt_q + 1'b1;
                if (run_cnt_q == dur_q - 16'd1) begin
                    state_d = ST_IDLE;
                    dir_d   = DIR_STOP;
                    duty_d  = '0;
                end
            end
        end
        ready_d = (state_d == ST_IDLE) || (state_d == ST_RUN && dur_d == '0);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_STOP;
            duty_q     <= '0;
            tgt_dir_q  <= DIR_STOP;
            tgt_duty_q <= '0;
            dur_q      <= '0;
            run_cnt_q  <= '0;
            dead_cnt_q <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            duty_q     <= duty_d;
            tgt_dir_q  <= tgt_dir_d;
            tgt_duty_q <= tgt_duty_d;
            dur_q      <= dur_d;
            run_cnt_q  <= run_cnt_d;
            dead_cnt_q <= dead_cnt_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign cmd_ready       = ready_q;
    assign robot_direction = dir_q;
    assign left_duty       = duty_q;
    assign right_duty      = duty_q;
    assign busy            = busy_q;
    assign cmd_error       = err_q;

endmodule

// File: tb/tb_motion_sequencer.sv
// tb_motion_sequencer: scoreboard bench checking output changes of motion_sequencer against expected values and timing
module tb_motion_sequencer;

    logic        clock_in = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  cmd_direction = '0;
    logic [7:0]  cmd_duty = '0;
    logic [15:0] cmd_duration = '0;
    logic        cmd_ready, busy, cmd_error;
    logic [2:0]  robot_direction;
    logic [7:0]  left_duty, right_duty;

    typedef struct {
        int dir;
        int duty;
        int off;
    } exp_t;

    exp_t sb[$];
    exp_t e_m;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   t0 = 0;
    int   prev_dir = 0;
    int   prev_duty = 0;

    motion_sequencer #(.TICK_DIV(10), .DEAD_MS(2), .RAMP_STEP(64)) dut (
        .clock_in        (clock_in),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_direction   (cmd_direction),
        .cmd_duty        (cmd_duty),
        .cmd_duration    (cmd_duration),
        .abort           (abort),
        .robot_direction (robot_direction),
        .left_duty       (left_duty),
        .right_duty      (right_duty),
        .busy            (busy),
        .cmd_error       (cmd_error)
    );

    always #5 clock_in = ~clock_in;

    always @(posedge clock_in) cyc++;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // every change of direction/duty must match the next expected entry, including its cycle offset from t0
    always @(negedge clock_in) begin
        if (reset) begin
            prev_dir  = int'(robot_direction);
            prev_duty = int'(left_duty);
        end else if (int'(robot_direction) != prev_dir || int'(left_duty) != prev_duty) begin
            if (sb.size() == 0) begin
                check("spurious_change", int'({robot_direction, left_duty}), -1);
            end else begin
                e_m = sb.pop_front();
                check("dir", int'(robot_direction), e_m.dir);
                check("left_duty", int'(left_duty), e_m.duty);
                check("right_duty", int'(right_duty), e_m.duty);
                check("time", cyc - t0, e_m.off);
            end
            prev_dir  = int'(robot_direction);
            prev_duty = int'(left_duty);
        end
    end

    task automatic push(input int d, input int u, input int o);
        sb.push_back(exp_t'{d, u, o});
    endtask

    task automatic send(input int d, input int u, input int dur);
        @(negedge clock_in);
        cmd_valid     = 1'b1;
        cmd_direction = 3'(d);
        cmd_duty      = 8'(u);
        cmd_duration  = 16'(dur);
        for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clock_in);
        check("ready_at_send", int'(cmd_ready), 1);
        @(posedge clock_in);
        #1;
        t0        = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clock_in);
        @(negedge clock_in);
        check("drain", sb.size(), 0);
        sb.delete();
    endtask

    task automatic idle_at_rest(input string tag);
        check({tag, "_dir"}, int'(robot_direction), 0);
        check({tag, "_duty"}, int'(left_duty), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_ready"}, int'(cmd_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clock_in);
        idle_at_rest("rst");
        check("rst_err", int'(cmd_error), 0);
        reset = 1'b0;
        @(negedge clock_in);
        check("post_rst_ready", int'(cmd_ready), 1);

        // forward 255 for 3 ticks: ramp every 10 cycles, 30 cycles at 255, then stop
        push(1, 0, 0); push(1, 64, 10); push(1, 128, 20); push(1, 192, 30); push(1, 255, 40); push(0, 0, 70);
        send(1, 255, 3);
        @(negedge clock_in);
        check("ramp_busy", int'(busy), 1);
        check("ramp_ready", int'(cmd_ready), 0);
        drain();
        idle_at_rest("timed_end");

        // untimed forward, then reversal through a 20-cycle dead interval
        push(1, 0, 0); push(1, 64, 10); push(1, 128, 20);
        send(1, 128, 0);
        drain();
        check("run0_ready", int'(cmd_ready), 1);
        check("run0_busy", int'(busy), 1);
        push(0, 0, 0); push(2, 0, 20); push(2, 64, 30); push(2, 100, 40);
        send(2, 100, 0);
        @(negedge clock_in);
        check("dead_ready", int'(cmd_ready), 0);
        drain();

        // reverse to forward 200, then same direction down to 50 without dead time
        push(0, 0, 0); push(1, 0, 20); push(1, 64, 30); push(1, 128, 40); push(1, 192, 50); push(1, 200, 60);
        send(1, 200, 0);
        drain();
        push(1, 136, 10); push(1, 72, 20); push(1, 50, 30);
        send(1, 50, 0);
        drain();

        // same duty: one RAMP cycle, then 2 ticks of RUN
        push(0, 0, 20);
        send(1, 50, 2);
        @(negedge clock_in);
        check("dur_ready", int'(cmd_ready), 0);
        drain();
        idle_at_rest("same_duty_end");

        // explicit stop command from RUN
        push(4, 0, 0); push(4, 64, 10); push(4, 128, 20);
        send(4, 128, 0);
        drain();
        push(0, 0, 0);
        send(0, 200, 0);
        @(negedge clock_in);
        check("stop_err", int'(cmd_error), 0);
        idle_at_rest("stop");

        // abort together with cmd_valid during RAMP
        push(3, 0, 0); push(3, 64, 10);
        send(3, 255, 0);
        drain();
        push(0, 0, 0);
        @(negedge clock_in);
        check("pre_abort_busy", int'(busy), 1);
        abort         = 1'b1;
        cmd_valid     = 1'b1;
        cmd_direction = 3'd4;
        cmd_duty      = 8'd77;
        cmd_duration  = 16'd0;
        @(posedge clock_in);
        #1;
        t0        = cyc;
        abort     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clock_in);
        idle_at_rest("abort");
        drain();
        repeat (30) @(negedge clock_in);
        idle_at_rest("abort_hold");

        // invalid direction from IDLE and from RUN
        send(6, 99, 5);
        @(negedge clock_in);
        check("err6_pulse", int'(cmd_error), 1);
        idle_at_rest("err6");
        @(negedge clock_in);
        check("err6_clear", int'(cmd_error), 0);
        push(1, 0, 0); push(1, 64, 10);
        send(1, 64, 0);
        drain();
        push(0, 0, 0);
        send(7, 0, 0);
        @(negedge clock_in);
        check("err7_pulse", int'(cmd_error), 1);
        @(negedge clock_in);
        check("err7_clear", int'(cmd_error), 0);
        idle_at_rest("err7");
        drain();

        // reset in DEAD discards the pending reversal
        push(1, 0, 0); push(1, 64, 10);
        send(1, 64, 0);
        drain();
        push(0, 0, 0);
        send(2, 64, 0);
        drain();
        repeat (5) @(negedge clock_in);
        check("dead_busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clock_in);
        idle_at_rest("rst_dead");
        check("rst_dead_err", int'(cmd_error), 0);
        reset = 1'b0;
        repeat (40) @(negedge clock_in);
        idle_at_rest("rst_dead_hold");
        check("final_queue", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
